// File: rtl/fifo_pop_bcd_pkg.sv
// Shared definitions for the FIFO read-side controller: FSM encoding and BCD geometry.
package fifo_pop_bcd_pkg;

  typedef enum logic [2:0] {
    StIdle    = 3'd0,
    StPop     = 3'd1,
    StCapture = 3'd2,
    StConvert = 3'd3,
    StDone    = 3'd4
  } state_e;

  localparam int unsigned BCD_DIGITS = 3;

endpackage

// File: rtl/fifo_pop_bcd_btn_debounce.sv
// Push-button front end: 2-flop synchroniser, level debounce and rising-edge one-shot.
module btn_debounce #(
  parameter int unsigned DB_CYCLES = 1_000_000,
  parameter int unsigned DB_W      = 20
) (
  input  logic CLK,
  input  logic RST,
  input  logic btn,
  output logic press
);

  logic            sync1;
  logic            sync2;
  logic            stable;
  logic [DB_W-1:0] cnt;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      sync1  <= 1'b0;
      sync2  <= 1'b0;
      stable <= 1'b0;
      cnt    <= '0;
      press  <= 1'b0;
    end else begin
      sync1 <= btn;
      sync2 <= sync1;
      press <= 1'b0;
      // Any sample matching the accepted level restarts the qualification window.
      if (sync2 == stable) begin
        cnt <= '0;
      end else if (cnt == DB_W'(DB_CYCLES - 1)) begin
        cnt    <= '0;
        stable <= sync2;
        press  <= sync2;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/fifo_pop_bcd.sv
// FIFO read controller: one pop per debounced press, then double-dabble of the word into 3 BCD digits.
module fifo_pop_bcd
  import fifo_pop_bcd_pkg::*;
#(
  parameter int unsigned WL        = 8,
  parameter int unsigned DL        = 4,
  parameter int unsigned DB_CYCLES = 1_000_000,
  parameter int unsigned DB_W      = 20
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          btn_rd,
  input  logic          empty,
  input  logic [WL-1:0] dout,
  output logic          rReq,
  output logic [DL-1:0] ones,
  output logic [DL-1:0] ten,
  output logic [DL-1:0] hund,
  output logic          valid,
  output logic          busy,
  output logic          underflow
);

  localparam int unsigned SR_W  = WL + BCD_DIGITS * DL;
  localparam int unsigned CNT_W = $clog2(WL + 1);

  logic            press;
  state_e          state;
  logic [SR_W-1:0] sr;
  logic [SR_W-1:0] sr_adj;
  logic [SR_W-1:0] sr_step;
  logic [CNT_W-1:0] iter;

  btn_debounce #(
    .DB_CYCLES(DB_CYCLES),
    .DB_W     (DB_W)
  ) u_btn (
    .CLK  (CLK),
    .RST  (RST),
    .btn  (btn_rd),
    .press(press)
  );

  // One double-dabble iteration: add 3 to every digit >= 5, then shift left.
  always_comb begin
    sr_adj = sr;
    for (int d = 0; d < int'(BCD_DIGITS); d++) begin
      if (sr[WL + d * DL +: DL] >= DL'(5)) begin
        sr_adj[WL + d * DL +: DL] = sr[WL + d * DL +: DL] + DL'(3);
      end
    end
    sr_step = {sr_adj[SR_W-2:0], 1'b0};
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state     <= StIdle;
      sr        <= '0;
      iter      <= '0;
      rReq      <= 1'b0;
      valid     <= 1'b0;
      busy      <= 1'b0;
      underflow <= 1'b0;
      ones      <= '0;
      ten       <= '0;
      hund      <= '0;
    end else begin
      rReq  <= 1'b0;
      valid <= 1'b0;
      case (state)
        StIdle: begin
          if (press) begin
            if (empty) begin
              underflow <= 1'b1;
            end else begin
              underflow <= 1'b0;
              rReq      <= 1'b1;
              busy      <= 1'b1;
              state     <= StPop;
            end
          end
        end
        StPop: begin
          state <= StCapture;
        end
        StCapture: begin
          sr    <= {{(BCD_DIGITS * DL){1'b0}}, dout};
          iter  <= '0;
          state <= StConvert;
        end
        StConvert: begin
          sr   <= sr_step;
          iter <= iter + 1'b1;
          // Digits are taken from the final shift so they are already valid during DONE.
          if (iter == CNT_W'(WL - 1)) begin
            hund  <= sr_step[WL + 2 * DL +: DL];
            ten   <= sr_step[WL + DL +: DL];
            ones  <= sr_step[WL +: DL];
            valid <= 1'b1;
            busy  <= 1'b0;
            state <= StDone;
          end
        end
        StDone: begin
          state <= StIdle;
        end
        default: begin
          state <= StIdle;
        end
      endcase
    end
  end

endmodule
